cpu_step_ctrl: RTL and testbench

//   Run/single-step/halt sequencer for the single-cycle core. It consumes the one-cycle tick from the

---
 rtl/cpu_step_ctrl_pkg.sv | 13 +
 rtl/cpu_step_ctrl_btn_debounce.sv | 48 ++++
 rtl/cpu_step_ctrl.sv | 135 +++++++++++++
 tb/tb_cpu_step_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared state encoding and defaults for the run/step/halt sequencer.
package cpu_step_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_STEP   = 2'd2;
  localparam state_t ST_HALTED = 2'd3;

  localparam int DEB_TICKS_DEF = 4;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, tick-paced debounce counter, rising-edge pulse.
module btn_debounce
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEB_TICKS - 1);

  logic [1:0]    sync;
  logic          din_sync;
  logic [CW-1:0] cnt;

  assign din_sync = sync[1];

  // cnt tracks consecutive disagreeing ticks; the terminal tick commits the new level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync       <= 2'b00;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync       <= {sync[0], din};
      rise_pulse <= 1'b0;
      if (tick) begin
        if (din_sync == level) begin
          cnt <= '0;
        end else if (cnt == CNT_TC) begin
          cnt        <= '0;
          level      <= din_sync;
          rise_pulse <= din_sync;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/single-step/halt sequencer issuing the core clock-enable from divider ticks.
// Optional breakpoint comparator enabled by defining BREAKPOINT_EN.
//
// state  | meaning
// IDLE   | core paused, waiting for run switch or step button
// RUN    | free-run, one cpu_en per tick until halt/breakpoint/switch off
// STEP   | waiting for the next tick to issue exactly one cpu_en
// HALTED | stopped by halt_req or breakpoint; leave only by dropping run_sw
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF,
  parameter int CNT_W     = 32,
  parameter int PC_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  state_t state_q;
  state_t state_d;
  logic   run_meta;
  logic   run_sync;
  logic   step_level;
  logic   step_pulse;
  logic   bp_hit;
  logic   cpu_en_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_meta <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      run_meta <= run_sw;
      run_sync <= run_meta;
    end
  end

  btn_debounce #(
    .DEB_TICKS (DEB_TICKS)
  ) u_step_deb (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .din        (step_btn),
    .level      (step_level),
    .rise_pulse (step_pulse)
  );

`ifdef BREAKPOINT_EN
  logic bp_skip;

  // Resuming from a breakpoint must execute the instruction at that PC once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bp_skip <= 1'b0;
    end else if (state_q == ST_HALTED && state_d == ST_IDLE) begin
      bp_skip <= 1'b1;
    end else if (cpu_en) begin
      bp_skip <= 1'b0;
    end
  end

  assign bp_hit = bp_valid & (pc == bp_addr) & ~bp_skip;
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_valid, step_level};
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run_sync)        state_d = ST_RUN;
        else if (step_pulse) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (halt_req || bp_hit) state_d = ST_HALTED;
        else if (!run_sync)     state_d = ST_IDLE;
      end
      ST_STEP: begin
        if (tick) state_d = ST_IDLE;
      end
      ST_HALTED: begin
        if (!run_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    halted   = (state_q == ST_HALTED);
    cpu_en_d = tick & (((state_q == ST_RUN) & ~halt_req & ~bp_hit) |
                       (state_q == ST_STEP));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_en <= 1'b0;
    end else begin
      cpu_en <= cpu_en_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (cpu_en) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed self-checking bench for cpu_step_ctrl (breakpoint scenario when BREAKPOINT_EN is defined).
module tb_cpu_step_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_req = 1'b0;
  logic [31:0] pc;
  logic [31:0] bp_addr = 32'h0;
  logic        bp_valid = 1'b0;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] cycle_count;

  logic        pc_load = 1'b0;
  logic [31:0] pc_init = 32'h0;

  int total = 0;
  int bad = 0;

  cpu_step_ctrl #(.DEB_TICKS(4), .CNT_W(32), .PC_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .halt_req    (halt_req),
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
    .cpu_en      (cpu_en),
    .state       (state),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;

  // minimal core model: PC advances by 4 on every enable
  always @(posedge clock) begin
    if (pc_load) pc <= pc_init;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic tick_period(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      idle(4);
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    total++; if (state !== 2'd0 || cpu_en !== 1'b0 || halted !== 1'b0 || cycle_count !== 32'd0) begin
      bad++; $display("FAIL reset_init: state=%0d cpu_en=%b halted=%b cnt=%0d want 0/0/0/0", state, cpu_en, halted, cycle_count); end
    @(posedge clock); #1 reset = 1'b0;
    run_sw = 1'b1;
    idle(3);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL reset_enter_run: state=%0d want 1", state); end
    cyc(1'b1);
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL reset_pre_en: cpu_en=%b want 1", cpu_en); end
    tick = 1'b0;
    reset = 1'b1;
    #2;
    total++; if (state !== 2'd0 || cpu_en !== 1'b0 || halted !== 1'b0 || cycle_count !== 32'd0) begin
      bad++; $display("FAIL reset_async: state=%0d cpu_en=%b halted=%b cnt=%0d want 0/0/0/0", state, cpu_en, halted, cycle_count); end
    reset = 1'b0;
    idle(3);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL reset_rerun: state=%0d want 1", state); end
  endtask

  task automatic test_run;
    int pulses;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) begin
        cyc(1'b0);
        total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL run_gap: tick %0d slot %0d cpu_en=%b want 0", k, j, cpu_en); end
      end
      cyc(1'b1);
      total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL run_pulse: tick %0d cpu_en=%b want 1", k, cpu_en); end
      else pulses++;
    end
    cyc(1'b0);
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL run_single: cpu_en=%b want 0", cpu_en); end
    total++; if (pulses != 10) begin bad++; $display("FAIL run_pulses: got %0d want 10", pulses); end
    total++; if (cycle_count !== 32'd10) begin bad++; $display("FAIL run_count: got %0d want 10", cycle_count); end
    run_sw = 1'b0;
    idle(3);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL run_exit: state=%0d want 0", state); end
  endtask

  task automatic test_debounce;
    step_btn = 1'b1;
    idle(3);
    cyc(1'b1);
    step_btn = 1'b0;
    idle(3);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1);
      total++; if (state !== 2'd0 || cpu_en !== 1'b0) begin
        bad++; $display("FAIL deb_glitch: tick %0d state=%0d cpu_en=%b want 0/0", k, state, cpu_en); end
      idle(4);
    end
    step_btn = 1'b1;
    idle(3);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1);
      total++; if (state !== 2'd0) begin bad++; $display("FAIL deb_hold: tick %0d state=%0d want 0", k, state); end
      if (k < 3) idle(4);
    end
    cyc(1'b0);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL deb_step: state=%0d want 2", state); end
    idle(3);
    total++; if (state !== 2'd2 || cpu_en !== 1'b0) begin
      bad++; $display("FAIL deb_wait: state=%0d cpu_en=%b want 2/0", state, cpu_en); end
    cyc(1'b1);
    total++; if (state !== 2'd0 || cpu_en !== 1'b1) begin
      bad++; $display("FAIL deb_exec: state=%0d cpu_en=%b want 0/1", state, cpu_en); end
    cyc(1'b0);
    total++; if (cycle_count !== 32'd11 || cpu_en !== 1'b0) begin
      bad++; $display("FAIL deb_count: cnt=%0d cpu_en=%b want 11/0", cycle_count, cpu_en); end
    idle(3);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1);
      idle(1);
      total++; if (state !== 2'd0) begin bad++; $display("FAIL deb_once: tick %0d state=%0d want 0", k, state); end
      idle(3);
    end
    step_btn = 1'b0;
    idle(3);
    tick_period(5);
    total++; if (cycle_count !== 32'd11) begin bad++; $display("FAIL deb_release: cnt=%0d want 11", cycle_count); end
  endtask

  task automatic test_halt;
    run_sw = 1'b1;
    idle(3);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL halt_run: state=%0d want 1", state); end
    halt_req = 1'b1;
    cyc(1'b1);
    halt_req = 1'b0;
    total++; if (state !== 2'd3 || halted !== 1'b1 || cpu_en !== 1'b0) begin
      bad++; $display("FAIL halt_enter: state=%0d halted=%b cpu_en=%b want 3/1/0", state, halted, cpu_en); end
    idle(1);
    cyc(1'b1);
    total++; if (state !== 2'd3 || cpu_en !== 1'b0) begin
      bad++; $display("FAIL halt_hold: state=%0d cpu_en=%b want 3/0", state, cpu_en); end
    run_sw = 1'b0;
    idle(3);
    total++; if (state !== 2'd0 || halted !== 1'b0) begin
      bad++; $display("FAIL halt_exit: state=%0d halted=%b want 0/0", state, halted); end
    total++; if (cycle_count !== 32'd11) begin bad++; $display("FAIL halt_count: cnt=%0d want 11", cycle_count); end
  endtask

  task automatic test_wrap;
    force dut.cycle_count = 32'hFFFF_FFFF;
    #1 release dut.cycle_count;
    idle(1);
    total++; if (cycle_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload: cnt=%0h want ffffffff", cycle_count); end
    step_btn = 1'b1;
    idle(3);
    tick_period(5);
    total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL wrap_zero: cnt=%0h want 0", cycle_count); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL wrap_state: state=%0d want 0", state); end
    step_btn = 1'b0;
    idle(3);
    tick_period(5);
  endtask

`ifdef BREAKPOINT_EN
  task automatic test_breakpoint;
    bp_addr = 32'h40;
    bp_valid = 1'b1;
    pc_init = 32'h38;
    pc_load = 1'b1;
    idle(1);
    pc_load = 1'b0;
    run_sw = 1'b1;
    idle(3);
    tick_period(2);
    total++; if (pc !== 32'h40 || state !== 2'd3) begin
      bad++; $display("FAIL bp_halt: pc=%0h state=%0d want 40/3", pc, state); end
    cyc(1'b1);
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL bp_no_en: cpu_en=%b want 0", cpu_en); end
    run_sw = 1'b0;
    idle(3);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL bp_idle: state=%0d want 0", state); end
    run_sw = 1'b1;
    idle(3);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL bp_resume: state=%0d want 1", state); end
    cyc(1'b1);
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL bp_skip: cpu_en=%b want 1", cpu_en); end
    idle(2);
    total++; if (pc !== 32'h44 || state !== 2'd1) begin
      bad++; $display("FAIL bp_past: pc=%0h state=%0d want 44/1", pc, state); end
    pc_init = 32'h3C;
    pc_load = 1'b1;
    idle(1);
    pc_load = 1'b0;
    tick_period(1);
    total++; if (pc !== 32'h40 || state !== 2'd3) begin
      bad++; $display("FAIL bp_again: pc=%0h state=%0d want 40/3", pc, state); end
    run_sw = 1'b0;
    bp_valid = 1'b0;
    idle(3);
  endtask
`endif

  initial begin
    pc = 32'h0;
    test_reset;
    test_run;
    test_debounce;
    test_halt;
    test_wrap;
`ifdef BREAKPOINT_EN
    test_breakpoint;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
